// File: rtl/activation_pkg.sv
// Shared types and constants for the activation arbiter slice.
//   act_arb_state_t : transaction FSM states (IDLE -> LOOKUP -> RESP -> IDLE)
//   ACT_DATA_W      : operand/result width of the shared function_lookup
package activation_pkg;

    localparam int unsigned ACT_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } act_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//   req          : per-requester request bits
//   last_grant   : index granted most recently; search starts one above it
//   grant_onehot : one-hot winner (all zero when no request)
//   grant_idx    : winner index (0 when no request)
module rr_arbiter #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic [N_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]  grant_idx
);

    logic            found;
    logic [ID_W-1:0] cand;

    // Walk last_grant+1, last_grant+2, ... with wrap; first hit wins.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        cand         = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((32'(last_grant) + k) % N_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        grant_onehot[grant_idx] = found;
    end

endmodule

// File: rtl/activation_arbiter.sv
// Shares one function_lookup between N_REQ requesters, one transaction at a time.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_x     : per-requester operand handshake (req_x packed, lane i at [i*DATA_W +: DATA_W])
//   req_ready           : one-hot accept strobe, combinational in the accept cycle
//   lut_x/lut_x_valid   : operand held to function_lookup for LUT_LATENCY+1 cycles
//   lut_y               : function_lookup result
//   rsp_valid/rsp_id/rsp_y/rsp_ready : tagged response channel with backpressure
module activation_arbiter
    import activation_pkg::*;
#(
    parameter  int unsigned N_REQ       = 4,
    parameter  int unsigned DATA_W      = ACT_DATA_W,
    parameter  int unsigned LUT_LATENCY = 1,
    localparam int unsigned ID_W        = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DATA_W-1:0]  req_x,
    output logic [N_REQ-1:0]         req_ready,
    output logic signed [DATA_W-1:0] lut_x,
    output logic                     lut_x_valid,
    input  logic signed [DATA_W-1:0] lut_y,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic signed [DATA_W-1:0] rsp_y,
    input  logic                     rsp_ready
);

    localparam int unsigned CNT_W = (LUT_LATENCY > 0) ? $clog2(LUT_LATENCY + 1) : 1;

    act_arb_state_t            state, state_nxt;
    logic [N_REQ-1:0]          grant_onehot;
    logic [ID_W-1:0]           grant_idx;
    logic [ID_W-1:0]           last_grant;
    logic [ID_W-1:0]           id_reg;
    logic [CNT_W-1:0]          cnt;
    logic signed [DATA_W-1:0]  x_reg;
    logic signed [DATA_W-1:0]  y_reg;
    logic [DATA_W-1:0]         x_sel;
    logic                      accept;
    logic                      lookup_done;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req          (req_valid),
        .last_grant   (last_grant),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    assign x_sel       = req_x[32'(grant_idx) * DATA_W +: DATA_W];
    assign lookup_done = (state == LOOKUP) && (cnt == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and accept strobe; no accept while rst so a request is never consumed by a reset cycle.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req_valid && !rst) begin
                    req_ready = grant_onehot;
                    accept    = 1'b1;
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (cnt == '0) state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand/result/id capture and ROM latency countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg      <= '0;
            y_reg      <= '0;
            id_reg     <= '0;
            cnt        <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else begin
            if (accept) begin
                x_reg      <= $signed(x_sel);
                id_reg     <= grant_idx;
                last_grant <= grant_idx;
                cnt        <= CNT_W'(LUT_LATENCY);
            end else if (state == LOOKUP && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (lookup_done) y_reg <= lut_y;
        end
    end

    // x_reg stays on lut_x through the whole lookup so x and the ROM word agree.
    assign lut_x       = x_reg;
    assign lut_x_valid = (state == LOOKUP);
    assign rsp_valid   = (state == RESP);
    assign rsp_id      = id_reg;
    assign rsp_y       = y_reg;

endmodule
